cpu_seq_ctrl: RTL

- Multi-cycle instruction sequencer for the 5-bit-opcode CPU.
- Sits between the combinational control decoder and the instruction/data memory ports.
- Steps each instruction through fetch, decode, execute, memory and writeback, using the decoder's halt/mem_write/sel_wb/reg_write/branch/jump outputs.
- Handles valid/ack memory handshakes, PC update, retire counting, and a memory-wait watchdog.

---
 rtl/cpu_seq_pkg.sv | 22 ++
 rtl/cpu_seq_watchdog.sv | 32 +++
 rtl/cpu_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_TGT = 1'b1;

  localparam int CNT_W_DEF   = 16;
  localparam int TO_W_DEF    = 8;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/cpu_seq_watchdog.sv
// Memory-wait watchdog: counts consecutive un-acked request cycles.
module cpu_seq_watchdog
  import cpu_seq_pkg::*;
#(
  parameter int TO_W    = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;

  // Fires in the cycle whose increment would reach TIMEOUT.
  assign expired = inc & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with memory watchdog.
// Optional perf counters enabled by CPU_SEQ_CTRL_PERF_EN.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TO_W    = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             halt,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             sel_wb,
  input  logic             beqz,
  input  logic             bnez,
  input  logic             bgez,
  input  logic             bltz,
  input  logic             jump,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state_q, state_d;
  logic   taken_q, we_q;
  logic   taken_now, retire;
  logic   wd_inc, wd_clr, wd_expired, wait_ack;

  assign taken_now = jump
                   | (beqz & alu_zero)
                   | (bnez & ~alu_zero)
                   | (bgez & ~alu_neg)
                   | (bltz & alu_neg);

  assign wait_ack = ((state_q == S_FETCH) & imem_ack)
                  | ((state_q == S_MEM) & dmem_ack);
  assign wd_inc   = ((state_q == S_FETCH) & ~imem_ack)
                  | ((state_q == S_MEM) & ~dmem_ack);
  assign wd_clr   = wait_ack | (state_d != state_q);

  cpu_seq_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    rf_write = 1'b0;
    retire  = 1'b0;
    pc_src  = PC_SRC_SEQ;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: state_d = halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (mem_write | sel_wb) begin
          state_d = S_MEM;
        end else if (reg_write) begin
          state_d = S_WB;
        end else begin
          // Taken flag is not registered yet; use the live value.
          retire  = 1'b1;
          pc_src  = taken_now;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (we_q) begin
            retire  = 1'b1;
            pc_src  = taken_q;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_write = 1'b1;
        retire   = 1'b1;
        pc_src   = taken_q;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  assign pc_write = retire;
  assign imem_req = (state_q == S_FETCH);
  assign dmem_req = (state_q == S_MEM);
  assign dmem_we  = (state_q == S_MEM) & we_q;
  assign halted   = (state_q == S_HALT);
  assign err      = (state_q == S_ERR);
  assign busy     = (state_q == S_FETCH) | (state_q == S_DECODE)
                  | (state_q == S_EXEC)  | (state_q == S_MEM)
                  | (state_q == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      taken_q    <= 1'b0;
      we_q       <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        taken_q <= 1'b0;
      end else if (state_q == S_EXEC) begin
        taken_q <= taken_now;
      end
      if (state_q == S_EXEC) we_q <= mem_write;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

`ifdef CPU_SEQ_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy)   cyc_q   <= cyc_q + CNT_W'(1);
      if (wd_inc) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
